// File: rtl/reg_op_pkg.sv
// Shared widths, opcodes and FSM state encoding for the register-op sequencer.
package reg_op_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  localparam logic [1:0] OP_LOADI = 2'b00;
  localparam logic [1:0] OP_MOV   = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SUB   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    WRITE  = 2'd3
  } seqState_t;
endpackage

// File: rtl/reg_op_sequencer_if.sv
// Op request/status handshake plus the register-file read and write ports.
interface reg_op_sequencer_if;
  logic                          start;
  logic [1:0]                    op;
  logic [reg_op_pkg::ADDR_W-1:0] src_a;
  logic [reg_op_pkg::ADDR_W-1:0] src_b;
  logic [reg_op_pkg::ADDR_W-1:0] dst;
  logic [reg_op_pkg::DATA_W-1:0] imm;
  logic                          busy;
  logic                          done;
  logic [reg_op_pkg::ADDR_W-1:0] rf_rAddr;
  logic [reg_op_pkg::DATA_W-1:0] rf_rData;
  logic                          rf_we;
  logic [reg_op_pkg::ADDR_W-1:0] rf_wAddr;
  logic [reg_op_pkg::DATA_W-1:0] rf_wData;

  modport slave (
    input  start, op, src_a, src_b, dst, imm, rf_rData,
    output busy, done, rf_rAddr, rf_we, rf_wAddr, rf_wData
  );

  modport master (
    output start, op, src_a, src_b, dst, imm, rf_rData,
    input  busy, done, rf_rAddr, rf_we, rf_wAddr, rf_wData
  );
endinterface

// File: rtl/reg_op_alu.sv
// Combinational result path for the sequencer; wraps modulo 2^DATA_W.
module reg_op_alu
  import reg_op_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      OP_LOADI: result = imm;
      OP_MOV:   result = opA;
      OP_ADD:   result = opA + opB;
      OP_SUB:   result = opA - opB;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// 2^ADDR_W x DATA_W register file: one combinational read port, one synchronous write port.
module Register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] rData,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData
);

  logic [DATA_W-1:0] regs [2**ADDR_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wAddr] <= wData;
    end
  end

  assign rData = regs[rAddr];

endmodule

// File: rtl/reg_op_sequencer.sv
// Multicycle micro-op sequencer: reads operands through the single register-file
// read port, computes LOADI/MOV/ADD/SUB, writes the result back and pulses done.
//
// state  | meaning
// IDLE   | waiting for start; request fields latched on acceptance
// READ_A | rf_rAddr = src_a, first operand captured at the edge
// READ_B | rf_rAddr = src_b, second operand captured at the edge (ADD/SUB)
// WRITE  | rf_we high, result driven to dst; done follows next cycle
module reg_op_sequencer
  import reg_op_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  reg_op_sequencer_if.slave  bus
);

  seqState_t         state, nextState;
  logic              accept;
  logic [1:0]        opReg;
  logic [ADDR_W-1:0] srcBReg;
  logic [ADDR_W-1:0] dstReg;
  logic [ADDR_W-1:0] rAddrReg;
  logic [DATA_W-1:0] immReg;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic              doneReg;
  logic [DATA_W-1:0] result;

  assign accept = (state == IDLE) && bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState    = state;
    bus.busy     = (state != IDLE);
    bus.rf_we    = 1'b0;
    bus.rf_wData = '0;
    bus.rf_wAddr = dstReg;
    bus.rf_rAddr = rAddrReg;
    bus.done     = doneReg;
    unique case (state)
      IDLE: begin
        if (bus.start) nextState = (bus.op == OP_LOADI) ? WRITE : READ_A;
      end
      READ_A: nextState = (opReg == OP_MOV) ? WRITE : READ_B;
      READ_B: nextState = WRITE;
      WRITE: begin
        bus.rf_we    = 1'b1;
        bus.rf_wData = result;
        nextState    = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // The read address is registered one state early so the combinational
  // read data is already valid for the whole READ_A/READ_B cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opReg    <= OP_LOADI;
      srcBReg  <= '0;
      dstReg   <= '0;
      rAddrReg <= '0;
      immReg   <= '0;
      opA      <= '0;
      opB      <= '0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= (state == WRITE);
      if (accept) begin
        opReg   <= bus.op;
        srcBReg <= bus.src_b;
        dstReg  <= bus.dst;
        immReg  <= bus.imm;
        if (bus.op != OP_LOADI) rAddrReg <= bus.src_a;
      end
      if (state == READ_A) begin
        opA <= bus.rf_rData;
        if (opReg != OP_MOV) rAddrReg <= srcBReg;
      end
      if (state == READ_B) opB <= bus.rf_rData;
    end
  end

  reg_op_alu u_alu (
    .op     (opReg),
    .imm    (immReg),
    .opA    (opA),
    .opB    (opB),
    .result (result)
  );

endmodule
